debounce_bank: RTL and testbench

Multi-channel switch/button debouncer, the parametrised successor of the single-input debounce block. Each channel synchronises its raw input and debounces both press and release symmetrically. Each channel also emits one-cycle rise/fall pulses and a bounce indicator. It sits between board switch/button pins and downstream logic such as counters, FSMs and LED drivers.

---
 rtl/debounce_bank.sv | 128 ++++++++++++
 tb/tb_debounce_bank.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel switch/button debouncer.
//
// Each channel passes its raw level through a SYNC_STAGES flop synchroniser,
// then requires DEBOUNCE_CNT consecutive cycles of disagreement with CLEAN
// before CLEAN takes the new level. Press and release are qualified the same
// way. Any single cycle of agreement restarts qualification from zero.
//
// Ports:
//   CLK    - system clock, all state on rising edge
//   RST    - asynchronous active-high reset
//   RAW    - raw asynchronous switch levels, one bit per channel
//   CLEAN  - debounced level per channel (registered)
//   RISE   - one-cycle pulse on the edge CLEAN goes 0->1
//   FALL   - one-cycle pulse on the edge CLEAN goes 1->0
//   BOUNCE - 1 while the synchronised input differs from CLEAN; 0 on the
//            edge CLEAN updates
module debounce_bank #(
   parameter int CHANNELS     = 4,
   parameter int DEBOUNCE_CNT = 1000000,
   parameter int CNT_W        = 20,
   parameter int SYNC_STAGES  = 2,
   parameter int RESET_LEVEL  = 0
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [CHANNELS-1:0] RAW,
   output logic [CHANNELS-1:0] CLEAN,
   output logic [CHANNELS-1:0] RISE,
   output logic [CHANNELS-1:0] FALL,
   output logic [CHANNELS-1:0] BOUNCE
);

   generate
      if (CHANNELS < 1) begin : g_err_channels
         $error("debounce_bank: CHANNELS must be >= 1");
      end
      if (DEBOUNCE_CNT < 1) begin : g_err_cnt
         $error("debounce_bank: DEBOUNCE_CNT must be >= 1");
      end
      if (SYNC_STAGES < 2) begin : g_err_sync
         $error("debounce_bank: SYNC_STAGES must be >= 2");
      end
      if ((CNT_W < 1) || (CNT_W > 62) ||
          ((longint'(1) << CNT_W) < longint'(DEBOUNCE_CNT))) begin : g_err_cntw
         $error("debounce_bank: CNT_W too small for DEBOUNCE_CNT");
      end
      if ((RESET_LEVEL != 0) && (RESET_LEVEL != 1)) begin : g_err_rstlvl
         $error("debounce_bank: RESET_LEVEL must be 0 or 1");
      end
   endgenerate

   localparam logic             RST_LVL = (RESET_LEVEL != 0);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT - 1);

   logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
   logic [CHANNELS-1:0] sync_w;

   logic [CNT_W-1:0]    cnt_q [CHANNELS];
   logic [CNT_W-1:0]    cnt_d [CHANNELS];
   logic [CHANNELS-1:0] clean_q,  clean_d;
   logic [CHANNELS-1:0] rise_q,   rise_d;
   logic [CHANNELS-1:0] fall_q,   fall_d;
   logic [CHANNELS-1:0] bounce_q, bounce_d;

   // Synchroniser chains, all channels side by side per stage.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= {CHANNELS{RST_LVL}};
         end
      end else begin
         sync_q[0] <= RAW;
         for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   assign sync_w = sync_q[SYNC_STAGES-1];

   // Qualification: the counter only advances while sync disagrees with
   // CLEAN; the edge that would reach DEBOUNCE_CNT commits the new level
   // instead, so the counter never leaves 0..DEBOUNCE_CNT-1.
   always_comb begin
      cnt_d    = cnt_q;
      clean_d  = clean_q;
      rise_d   = '0;
      fall_d   = '0;
      bounce_d = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (sync_w[i] == clean_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            cnt_d[i]   = '0;
            clean_d[i] = sync_w[i];
            rise_d[i]  = sync_w[i];
            fall_d[i]  = ~sync_w[i];
         end else begin
            cnt_d[i]    = cnt_q[i] + 1'b1;
            bounce_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= '0;
         end
         clean_q  <= {CHANNELS{RST_LVL}};
         rise_q   <= '0;
         fall_q   <= '0;
         bounce_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         clean_q  <= clean_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         bounce_q <= bounce_d;
      end
   end

   assign CLEAN  = clean_q;
   assign RISE   = rise_q;
   assign FALL   = fall_q;
   assign BOUNCE = bounce_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: instance A (4 ch, DEBOUNCE_CNT=8, reset level 0)
// and instance B (4 ch, DEBOUNCE_CNT=1, reset level 1). Expected output
// values are queued with the cycle they fall due and checked after that edge.
module tb_debounce_bank;

   localparam int SS    = 2;
   localparam int DC_A  = 8;
   localparam int DC_B  = 1;
   localparam int LAT_A = SS + DC_A - 1;
   localparam int LAT_B = SS + DC_B - 1;

   logic       clk = 1'b0;
   logic       rst_a, rst_b;
   logic [3:0] raw_a, raw_b;
   logic [3:0] clean_a, rise_a, fall_a, bounce_a;
   logic [3:0] clean_b, rise_b, fall_b, bounce_b;

   always #5 clk = ~clk;

   debounce_bank #(
      .CHANNELS(4), .DEBOUNCE_CNT(DC_A), .CNT_W(3), .SYNC_STAGES(SS), .RESET_LEVEL(0)
   ) dut_a (
      .CLK(clk), .RST(rst_a), .RAW(raw_a),
      .CLEAN(clean_a), .RISE(rise_a), .FALL(fall_a), .BOUNCE(bounce_a)
   );

   debounce_bank #(
      .CHANNELS(4), .DEBOUNCE_CNT(DC_B), .CNT_W(1), .SYNC_STAGES(SS), .RESET_LEVEL(1)
   ) dut_b (
      .CLK(clk), .RST(rst_b), .RAW(raw_b),
      .CLEAN(clean_b), .RISE(rise_b), .FALL(fall_b), .BOUNCE(bounce_b)
   );

   typedef struct {
      int         due;
      string      tag;
      int         sel;
      logic [3:0] mask;
      logic [3:0] val;
   } sb_t;

   sb_t sb[$];
   int  cyc      = 0;
   int  n_checks = 0;
   int  n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   // sel 0..3: A CLEAN/RISE/FALL/BOUNCE, 4..7: same for B
   function automatic logic [3:0] pick(input int sel);
      case (sel)
         0:       return clean_a;
         1:       return rise_a;
         2:       return fall_a;
         3:       return bounce_a;
         4:       return clean_b;
         5:       return rise_b;
         6:       return fall_b;
         default: return bounce_b;
      endcase
   endfunction

   task automatic expect_at(input int due, input string tag, input int sel,
                            input logic [3:0] mask, input logic [3:0] val);
      sb_t e;
      e.due = due; e.tag = tag; e.sel = sel; e.mask = mask; e.val = val;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due == cyc) begin
            check(sb[i].tag, 32'(pick(sb[i].sel) & sb[i].mask), 32'(sb[i].val & sb[i].mask));
            sb.delete(i);
         end
      end
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   // Clean step of channel ch to level lvl driven just after cycle t0;
   // edge k of the step completes at cycle t0+1+k.
   task automatic press_expect(input int dut, input int ch, input logic lvl, input int t0);
      int         lat;
      int         b;
      logic [3:0] m, hi, lo;
      lat = (dut != 0) ? LAT_B : LAT_A;
      b   = dut * 4;
      m   = 4'(1 << ch);
      hi  = lvl ? m : 4'b0000;
      lo  = lvl ? 4'b0000 : m;
      expect_at(t0 + lat,     $sformatf("clean_pre%0d_%0d", dut, ch),  b + 0, m, lo);
      expect_at(t0 + 1 + lat, $sformatf("clean_upd%0d_%0d", dut, ch),  b + 0, m, hi);
      expect_at(t0 + lat,     $sformatf("rise_pre%0d_%0d", dut, ch),   b + 1, m, '0);
      expect_at(t0 + 1 + lat, $sformatf("rise_upd%0d_%0d", dut, ch),   b + 1, m, hi);
      expect_at(t0 + 2 + lat, $sformatf("rise_post%0d_%0d", dut, ch),  b + 1, m, '0);
      expect_at(t0 + lat,     $sformatf("fall_pre%0d_%0d", dut, ch),   b + 2, m, '0);
      expect_at(t0 + 1 + lat, $sformatf("fall_upd%0d_%0d", dut, ch),   b + 2, m, lo);
      expect_at(t0 + 2 + lat, $sformatf("fall_post%0d_%0d", dut, ch),  b + 2, m, '0);
      for (int k = 1; k <= lat; k++) begin
         expect_at(t0 + 1 + k, $sformatf("bounce%0d_%0d_e%0d", dut, ch, k), b + 3, m,
                   ((k >= 2) && (k < lat)) ? m : 4'b0000);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      rst_a = 1'b1; rst_b = 1'b1;
      raw_a = 4'b0000; raw_b = 4'b1111;

      // Reset held: A all zero, B CLEAN at reset level 1
      for (int k = 1; k <= 3; k++) begin
         for (int s = 0; s < 4; s++) expect_at(k, $sformatf("rst_a_s%0d", s), s, 4'hF, 4'h0);
         expect_at(k, "rst_b_clean", 4, 4'hF, 4'hF);
         for (int s = 5; s < 8; s++) expect_at(k, $sformatf("rst_b_s%0d", s), s, 4'hF, 4'h0);
      end
      run(3);

      // Idle after release
      rst_a = 1'b0; rst_b = 1'b0;
      for (int k = 1; k <= 50; k++) begin
         for (int s = 0; s < 4; s++) expect_at(cyc + k, $sformatf("idle_a_s%0d", s), s, 4'hF, 4'h0);
      end
      for (int k = 1; k <= 5; k++) begin
         expect_at(cyc + k, "idle_b_clean", 4, 4'hF, 4'hF);
         expect_at(cyc + k, "idle_b_rise", 5, 4'hF, 4'h0);
         expect_at(cyc + k, "idle_b_fall", 6, 4'hF, 4'h0);
      end
      run(50);

      // Clean press and release on channel 0
      t = cyc; raw_a[0] = 1'b1;
      press_expect(0, 0, 1'b1, t);
      expect_at(t + 1 + LAT_A, "press_others", 0, 4'hE, 4'h0);
      run(LAT_A + 4);
      t = cyc; raw_a[0] = 1'b0;
      press_expect(0, 0, 1'b0, t);
      run(LAT_A + 4);

      // Bounce rejection on channel 1: toggle every 3 cycles, then hold 1
      for (int k = 0; k < 60; k++) begin
         if (k % 3 == 0) raw_a[1] = ~raw_a[1];
         expect_at(cyc + 1, "bnc_clean1", 0, 4'h2, 4'h0);
         expect_at(cyc + 1, "bnc_rise1", 1, 4'h2, 4'h0);
         tick();
      end
      t = cyc; raw_a[1] = 1'b1;
      press_expect(0, 1, 1'b1, t);
      for (int k = LAT_A + 2; k <= LAT_A + 5; k++) expect_at(t + 1 + k, "bnc_single_rise1", 1, 4'h2, 4'h0);
      run(LAT_A + 6);
      t = cyc; raw_a[1] = 1'b0;
      press_expect(0, 1, 1'b0, t);
      run(LAT_A + 4);

      // Independence: ch1 and ch3 step high, ch3 glitches low one cycle
      t = cyc; raw_a = 4'b1010;
      press_expect(0, 1, 1'b1, t);
      expect_at(t + 1 + 6,  "ind_bnc3_e6", 3, 4'h8, 4'h8);
      expect_at(t + 1 + 7,  "ind_bnc3_e7", 3, 4'h8, 4'h0);
      expect_at(t + 1 + 8,  "ind_bnc3_e8", 3, 4'h8, 4'h8);
      expect_at(t + 1 + 9,  "ind_rise3_e9", 1, 4'h8, 4'h0);
      expect_at(t + 1 + 14, "ind_clean3_pre", 0, 4'h8, 4'h0);
      expect_at(t + 1 + 15, "ind_clean3_upd", 0, 4'h8, 4'h8);
      expect_at(t + 1 + 15, "ind_rise3_upd", 1, 4'h8, 4'h8);
      expect_at(t + 1 + 16, "ind_rise3_post", 1, 4'h8, 4'h0);
      for (int k = 0; k <= 17; k++) begin
         expect_at(t + 1 + k, "ind_clean02", 0, 4'h5, 4'h0);
         expect_at(t + 1 + k, "ind_rise02", 1, 4'h5, 4'h0);
         expect_at(t + 1 + k, "ind_fall_all", 2, 4'hF, 4'h0);
      end
      for (int k = 0; k < 20; k++) begin
         tick();
         if (cyc == t + 1 + 4) raw_a[3] = 1'b0;
         if (cyc == t + 1 + 5) raw_a[3] = 1'b1;
      end
      t = cyc; raw_a = 4'b0000;
      press_expect(0, 1, 1'b0, t);
      press_expect(0, 3, 1'b0, t);
      run(LAT_A + 4);

      // Async reset in the middle of qualification on channel 0
      t = cyc; raw_a[0] = 1'b1;
      expect_at(t + 7, "arst_pre_bounce0", 3, 4'h1, 4'h1);
      run(7);
      #2;
      rst_a = 1'b1;
      #1;
      check("arst_clean", 32'(clean_a), 32'h0);
      check("arst_rise", 32'(rise_a), 32'h0);
      check("arst_fall", 32'(fall_a), 32'h0);
      check("arst_bounce", 32'(bounce_a), 32'h0);
      for (int k = 1; k <= 3; k++) begin
         for (int s = 0; s < 4; s++) expect_at(cyc + k, $sformatf("arst_hold_s%0d", s), s, 4'hF, 4'h0);
      end
      run(3);
      rst_a = 1'b0;
      t = cyc;
      press_expect(0, 0, 1'b1, t);
      run(LAT_A + 4);
      t = cyc; raw_a[0] = 1'b0;
      press_expect(0, 0, 1'b0, t);
      run(LAT_A + 4);

      // DEBOUNCE_CNT=1, reset level 1: channel 2 falls then rises
      t = cyc; raw_b[2] = 1'b0;
      press_expect(1, 2, 1'b0, t);
      expect_at(t + 1 + LAT_B, "b_clean_others", 4, 4'hB, 4'hB);
      for (int k = 0; k <= 4; k++) expect_at(t + 1 + k, "b_bounce", 7, 4'hF, 4'h0);
      run(6);
      t = cyc; raw_b[2] = 1'b1;
      press_expect(1, 2, 1'b1, t);
      run(6);

      // DEBOUNCE_CNT=1: every change of channel 0 yields a pulse
      for (int k = 0; k < 4; k++) begin
         t = cyc; raw_b[0] = ~raw_b[0];
         press_expect(1, 0, raw_b[0], t);
         expect_at(t + 1, "b_toggle_bounce", 7, 4'hF, 4'h0);
         run(2);
      end
      run(6);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
